// File: rtl/aes_pkg.sv
// Shared AES definitions for the round datapath blocks.
//   NUM_BYTES/BYTE_W/STATE_W : state geometry (16 x 8 = 128 bits)
//   state_t                  : one 128-bit AES state, byte 0 in [127:120]
//   sb_fsm_e                 : SubBytes requester FSM states
//   get_byte()               : extract byte idx of a state (byte 0 = MSB)
package aes_pkg;
  localparam int NUM_BYTES = 16;
  localparam int BYTE_W    = 8;
  localparam int STATE_W   = NUM_BYTES * BYTE_W;

  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sb_fsm_e;

  function automatic logic [BYTE_W-1:0] get_byte(input state_t s, input logic [3:0] idx);
    return s[(STATE_W-1) - BYTE_W*int'(idx) -: BYTE_W];
  endfunction
endpackage

// File: rtl/sub_bytes_collect.sv
// Response-side byte assembler for the SubBytes requester.
//   clk, rst       : clock, async active-high reset
//   clear_i        : new operation accepted; restart byte index at 0
//   run_i          : requester is in RUN; responses outside RUN are dropped
//   outst_zero_i   : no lookup currently outstanding
//   rsp_vld_i/data : S-box response strobe and substituted byte (in order)
//   ack_o          : response accepted this cycle (retires one lookup)
//   last_o         : the accepted response is the 16th byte
//   state_out_o    : assembled result, byte 0 in [127:120]
//   err_o          : sticky, a response arrived in RUN with nothing outstanding
module sub_bytes_collect
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              run_i,
  input  logic              outst_zero_i,
  input  logic              rsp_vld_i,
  input  logic [BYTE_W-1:0] rsp_data_i,
  output logic              ack_o,
  output logic              last_o,
  output state_t            state_out_o,
  output logic              err_o
);
  logic [4:0] resp_cnt_q;
  state_t     state_out_q;
  logic       err_q;
  logic       hit, unexp;

  assign hit    = run_i && rsp_vld_i;
  // Saturation guard on resp_cnt keeps the byte index from ever passing 15.
  assign ack_o  = hit && !outst_zero_i && (resp_cnt_q < 5'(NUM_BYTES));
  assign unexp  = hit && outst_zero_i;
  assign last_o = ack_o && (resp_cnt_q == 5'(NUM_BYTES-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_cnt_q  <= '0;
      state_out_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (clear_i)    resp_cnt_q <= '0;
      else if (ack_o) resp_cnt_q <= resp_cnt_q + 5'd1;
      // Unexpected data is discarded; only the flag records it.
      if (unexp) err_q <= 1'b1;
      for (int i = 0; i < NUM_BYTES; i++)
        if (ack_o && resp_cnt_q == 5'(i))
          state_out_q[(STATE_W-1) - BYTE_W*i -: BYTE_W] <= rsp_data_i;
    end
  end

  assign state_out_o = state_out_q;
  assign err_o       = err_q;
endmodule

// File: rtl/sub_bytes_req.sv
// SubBytes requester: streams the 16 bytes of a latched state into the
// shared S-box LUT one per cycle, honouring arbiter availability and an
// outstanding-lookup limit, and returns the assembled substituted state.
//   clk, reset                 : clock, async active-high reset
//   start, state_in            : request (sampled in IDLE only) and input state
//   busy                       : high in RUN and DONE
//   sub_bytes_val(_vld)        : registered S-box lookup request
//   sbox_available             : arbiter lets a request through this cycle
//   sub_bytes_sbox_data(_vld)  : in-order S-box responses
//   state_out, state_out_vld   : result and its one-cycle completion pulse
//   err                        : sticky unexpected-response flag
module sub_bytes_req #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STATE_W         = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  output logic               busy,
  output logic [7:0]         sub_bytes_val,
  output logic               sub_bytes_val_vld,
  input  logic               sbox_available,
  input  logic [7:0]         sub_bytes_sbox_data,
  input  logic               sub_bytes_sbox_data_vld,
  output logic [STATE_W-1:0] state_out,
  output logic               state_out_vld,
  output logic               err
);
  import aes_pkg::*;

  localparam int OUT_W = 3;  // holds 0..4

  sb_fsm_e           state_q;
  state_t            src_q;
  logic [4:0]        issue_cnt_q;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic [BYTE_W-1:0] val_q;
  logic              val_vld_q, out_vld_q;
  logic              run, ack, last, issue;

  assign run = (state_q == RUN);

  // A response retiring in the same cycle frees a slot, so a full window
  // still issues back-to-back when the S-box keeps up.
  assign issue = run && (issue_cnt_q < 5'(NUM_BYTES)) && sbox_available &&
                 ((outst_q < OUT_W'(MAX_OUTSTANDING)) || ack);

  always_comb begin
    outst_d = outst_q;
    if (issue && !ack)      outst_d = outst_q + 1'b1;
    else if (!issue && ack) outst_d = outst_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      issue_cnt_q <= '0;
      outst_q     <= '0;
      val_q       <= '0;
      val_vld_q   <= 1'b0;
      out_vld_q   <= 1'b0;
    end else begin
      val_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          src_q       <= state_in;
          issue_cnt_q <= '0;
          outst_q     <= '0;
          state_q     <= RUN;
        end
        RUN: begin
          if (issue) begin
            val_q       <= get_byte(src_q, issue_cnt_q[3:0]);
            val_vld_q   <= 1'b1;
            issue_cnt_q <= issue_cnt_q + 5'd1;
          end
          outst_q <= outst_d;
          if (last) begin
            state_q   <= DONE;
            out_vld_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  sub_bytes_collect u_collect (
    .clk          (clk),
    .rst          (reset),
    .clear_i      ((state_q == IDLE) && start),
    .run_i        (run),
    .outst_zero_i (outst_q == '0),
    .rsp_vld_i    (sub_bytes_sbox_data_vld),
    .rsp_data_i   (sub_bytes_sbox_data),
    .ack_o        (ack),
    .last_o       (last),
    .state_out_o  (state_out),
    .err_o        (err)
  );

  assign busy              = (state_q != IDLE);
  assign sub_bytes_val     = val_q;
  assign sub_bytes_val_vld = val_vld_q;
  assign state_out_vld     = out_vld_q;
endmodule

// File: tb/tb_sub_bytes_req.sv
// Directed bench for sub_bytes_req. u1: MAX_OUTSTANDING=2 with a 1-cycle
// S-box; u2: MAX_OUTSTANDING=1 with a 2-cycle S-box. Cycle numbers are
// rising-edge counts; outputs are sampled on the falling edge.
module tb_sub_bytes_req;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [127:0] VEC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] EXP0 = {16{8'h63}};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8*int'(b) -: 8];
  endfunction

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // u1 signals
  logic start1 = 1'b0, avail1 = 1'b1, inj1 = 1'b0;
  logic [127:0] sin1 = '0, sout1;
  logic [7:0] val1, rd1, injd1 = '0;
  logic busy1, vld1, rv1, ovld1, err1;
  // u2 signals
  logic start2 = 1'b0;
  logic [127:0] sin2 = '0, sout2;
  logic [7:0] val2, rd2;
  logic busy2, vld2, rv2, ovld2, err2;

  sub_bytes_req #(.MAX_OUTSTANDING(2)) u1 (
    .clk(clk), .reset(rst), .start(start1), .state_in(sin1), .busy(busy1),
    .sub_bytes_val(val1), .sub_bytes_val_vld(vld1), .sbox_available(avail1),
    .sub_bytes_sbox_data(rd1), .sub_bytes_sbox_data_vld(rv1),
    .state_out(sout1), .state_out_vld(ovld1), .err(err1));

  sub_bytes_req #(.MAX_OUTSTANDING(1)) u2 (
    .clk(clk), .reset(rst), .start(start2), .state_in(sin2), .busy(busy2),
    .sub_bytes_val(val2), .sub_bytes_val_vld(vld2), .sbox_available(1'b1),
    .sub_bytes_sbox_data(rd2), .sub_bytes_sbox_data_vld(rv2),
    .state_out(sout2), .state_out_vld(ovld2), .err(err2));

  // S-box models: fixed latency, plus a manual injection port on u1
  logic p1v = 1'b0, q0v = 1'b0, q1v = 1'b0;
  logic [7:0] p1d = '0, q0d = '0, q1d = '0;
  always @(posedge clk) begin
    p1v <= vld1; p1d <= sbox(val1);
    q0v <= vld2; q0d <= sbox(val2);
    q1v <= q0v;  q1d <= q0d;
  end
  assign rv1 = p1v | inj1;
  assign rd1 = inj1 ? injd1 : p1d;
  assign rv2 = q1v;
  assign rd2 = q1d;

  // Monitors
  logic [7:0] req1_b[$];
  int req1_c[$];
  int vld1_n = 0, vld1_cyc = -1;
  int req2_n = 0, vld2_n = 0, out2 = 0, max_out2 = 0, gap_min2 = 1000, last_req2 = -1;
  always @(negedge clk) begin
    if (vld1 === 1'b1) begin req1_b.push_back(val1); req1_c.push_back(cyc); end
    if (ovld1 === 1'b1) begin vld1_n++; vld1_cyc = cyc; end
    if (vld2 === 1'b1) begin
      req2_n++;
      if (last_req2 >= 0 && cyc - last_req2 < gap_min2) gap_min2 = cyc - last_req2;
      last_req2 = cyc;
    end
    if (ovld2 === 1'b1) vld2_n++;
    out2 = out2 + int'(vld2 === 1'b1) - int'(rv2 === 1'b1);
    if (out2 > max_out2) max_out2 = out2;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] seq1(input int base);
    logic [127:0] s = '0;
    for (int i = 0; i < 16; i++)
      if (base + i < req1_b.size()) s = {s[119:0], req1_b[base+i]};
    return s;
  endfunction

  function automatic int reqs_in(input int base, input int lo, input int hi);
    int n = 0;
    for (int i = base; i < req1_c.size(); i++)
      if (req1_c[i] >= lo && req1_c[i] <= hi) n++;
    return n;
  endfunction

  int T, b, v;
  task automatic go1(input logic [127:0] s, output int t);
    @(negedge clk); start1 = 1'b1; sin1 = s;
    @(negedge clk); start1 = 1'b0; t = cyc;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state_out", sout1, '0);
    chk("rst_ctrl", {busy1, vld1, ovld1, err1, val1}, '0);
    chk("rst_u2", {sout2, busy2, vld2, ovld2, err2}, '0);
    rst = 1'b0;

    // Basic vector
    b = req1_b.size(); v = vld1_n;
    go1(VEC, T);
    chk("basic_busy", busy1, 1);
    repeat (22) @(negedge clk);
    chk("basic_req_cnt", req1_b.size() - b, 16);
    chk("basic_first_req", req1_c[b], T + 1);
    chk("basic_last_req", req1_c[b+15], T + 16);
    chk("basic_bytes", seq1(b), VEC);
    chk("basic_result", sout1, EXP);
    chk("basic_vld_cnt", vld1_n - v, 1);
    chk("basic_vld_cyc", vld1_cyc, T + 18);
    chk("basic_idle_err", {busy1, err1}, 0);

    // Contention: S-box unavailable at edges T+4..T+9
    b = req1_b.size();
    go1(VEC, T);
    repeat (3) @(negedge clk); avail1 = 1'b0;
    repeat (6) @(negedge clk); avail1 = 1'b1;
    repeat (20) @(negedge clk);
    chk("cont_req_cnt", req1_b.size() - b, 16);
    chk("cont_window", reqs_in(b, T + 4, T + 9), 0);
    chk("cont_bytes", seq1(b), VEC);
    chk("cont_result", sout1, EXP);
    chk("cont_vld_cyc", vld1_cyc, T + 24);

    // Start while busy
    b = req1_b.size(); v = vld1_n;
    go1(VEC, T);
    repeat (4) @(negedge clk); start1 = 1'b1; sin1 = '0;
    @(negedge clk); start1 = 1'b0;
    repeat (25) @(negedge clk);
    chk("busy_start_vld_cnt", vld1_n - v, 1);
    chk("busy_start_bytes", seq1(b), VEC);
    chk("busy_start_result", sout1, EXP);

    // Spurious response in RUN before any lookup is outstanding
    go1(VEC, T);
    inj1 = 1'b1; injd1 = 8'h5a;
    @(negedge clk); inj1 = 1'b0;
    chk("spur_err_set", err1, 1);
    repeat (20) @(negedge clk);
    chk("spur_result", sout1, EXP);
    chk("spur_vld_cyc", vld1_cyc, T + 18);
    chk("spur_err_sticky", err1, 1);

    // Mid-operation reset, then a stray response in IDLE
    go1(VEC, T);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_state_out", sout1, '0);
    chk("mrst_ctrl", {busy1, vld1, ovld1, err1, val1}, '0);
    @(negedge clk); rst = 1'b0; inj1 = 1'b1; injd1 = 8'h77;
    @(negedge clk); inj1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_dropped", {sout1, busy1, err1}, '0);
    go1('0, T);
    repeat (22) @(negedge clk);
    chk("zero_result", sout1, EXP0);
    chk("zero_vld_cyc", vld1_cyc, T + 18);
    chk("zero_err", err1, 0);

    // Outstanding limit 1 with 2-cycle S-box
    @(negedge clk); start2 = 1'b1; sin2 = VEC;
    @(negedge clk); start2 = 1'b0;
    repeat (60) @(negedge clk);
    chk("lim_req_cnt", req2_n, 16);
    chk("lim_max_outst", max_out2, 1);
    chk("lim_no_b2b", gap_min2 >= 2, 1);
    chk("lim_result", sout2, EXP);
    chk("lim_vld_cnt", vld2_n, 1);
    chk("lim_idle_err", {busy2, err2}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
